// File: rtl/v_issue_queue.sv
// ----------------------------------------------------------------------------
// v_issue_queue
//
// In-order issue queue between a scalar core and a vector unit. The scalar
// core pushes decoded vector instructions together with a tag and a snapshot
// of the vector-length register. The head entry is offered to the vector
// unit, popped when the unit accepts it, and the next entry is not offered
// until the unit signals that the accepted instruction has completed.
//
// Optional feature macro: V_ISSUE_PERF_EN adds the perf_issued / perf_stall
// performance counters. The default build has neither port nor logic.
//
// Parameters
//   DEPTH  number of queue entries (power of two, 2..16)
//   PKT_W  width of the opaque decoded-instruction packet
//   VL_W   width of the vector-length field
//   ID_W   width of the instruction tag
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   I_start      enqueue request (one instruction per cycle)
//   I_pkt/I_id   packet and tag of the instruction being enqueued
//   vl           current vector length, captured at enqueue
//   I_clear      synchronous flush, highest priority
//   stall        queue full, scalar core must hold its request
//   DONE         queue empty and nothing outstanding
//   iss_valid    head entry offered to the vector unit
//   iss_pkt/iss_vl/iss_id  offered entry fields
//   vu_ready     vector unit accepts the offered entry
//   vu_done      single-cycle completion pulse for the accepted entry
//   level        number of queued entries
//   perf_issued  (V_ISSUE_PERF_EN) pops since reset/clear, wraps at 2^32
//   perf_stall   (V_ISSUE_PERF_EN) cycles with I_start while full
// ----------------------------------------------------------------------------
module v_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PKT_W = 64,
    parameter int unsigned VL_W  = 9,
    parameter int unsigned ID_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     I_start,
    input  logic [PKT_W-1:0]         I_pkt,
    input  logic [ID_W-1:0]          I_id,
    input  logic [VL_W-1:0]          vl,
    input  logic                     I_clear,
    output logic                     stall,
    output logic                     DONE,
    output logic                     iss_valid,
    output logic [PKT_W-1:0]         iss_pkt,
    output logic [VL_W-1:0]          iss_vl,
    output logic [ID_W-1:0]          iss_id,
    input  logic                     vu_ready,
    input  logic                     vu_done,
    output logic [$clog2(DEPTH):0]   level
`ifdef V_ISSUE_PERF_EN
    ,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_stall
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StWait
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PKT_W-1:0]   iss_pkt_q, iss_pkt_d;
    logic [VL_W-1:0]    iss_vl_q, iss_vl_d;
    logic [ID_W-1:0]    iss_id_q, iss_id_d;

    // Entry storage; contents are only meaningful between the pointers, so it
    // needs no reset.
    logic [PKT_W-1:0]   pkt_mem_q [DEPTH];
    logic [VL_W-1:0]    vl_mem_q  [DEPTH];
    logic [ID_W-1:0]    id_mem_q  [DEPTH];

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic full;
    logic enq;
    logic pop;
    logic load_iss;

    always_comb begin
        full = (level_q == LVL_W'(DEPTH));
        // Full is judged on the registered level, so a pop in the same cycle
        // does not make room for a new entry.
        enq  = I_start && !full && !I_clear;
        pop  = (state_q == StOffer) && vu_ready && !I_clear;
    end

    // ------------------------------------------------------------------------
    // Pointer / level next state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (I_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            level_d  = level_q + LVL_W'(enq) - LVL_W'(pop);
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        load_iss = 1'b0;
        if (I_clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Only registered level counts, so an entry written this
                    // cycle is never offered before the next one.
                    if (level_q != '0) begin
                        state_d  = StOffer;
                        load_iss = 1'b1;
                    end
                end
                StOffer: begin
                    if (vu_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (vu_done) begin
                        if (level_d != '0) begin
                            state_d  = StOffer;
                            load_iss = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Offered entry registers
    // ------------------------------------------------------------------------
    always_comb begin
        iss_pkt_d = iss_pkt_q;
        iss_vl_d  = iss_vl_q;
        iss_id_d  = iss_id_q;
        if (I_clear) begin
            iss_pkt_d = '0;
            iss_vl_d  = '0;
            iss_id_d  = '0;
        end else if (load_iss) begin
            if (level_q != '0) begin
                iss_pkt_d = pkt_mem_q[rd_ptr_q];
                iss_vl_d  = vl_mem_q[rd_ptr_q];
                iss_id_d  = id_mem_q[rd_ptr_q];
            end else begin
                // Leaving WAIT on an empty queue: the only entry is the one
                // being written at this edge, so capture it from the inputs.
                iss_pkt_d = I_pkt;
                iss_vl_d  = vl;
                iss_id_d  = I_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            iss_pkt_q <= '0;
            iss_vl_q  <= '0;
            iss_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            iss_pkt_q <= iss_pkt_d;
            iss_vl_q  <= iss_vl_d;
            iss_id_q  <= iss_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pkt_mem_q[wr_ptr_q] <= I_pkt;
            vl_mem_q[wr_ptr_q]  <= vl;
            id_mem_q[wr_ptr_q]  <= I_id;
        end
    end

    // ------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------
`ifdef V_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (I_clear) begin
            perf_issued_d = '0;
            perf_stall_d  = '0;
        end else begin
            perf_issued_d = perf_issued_q + 32'(pop);
            perf_stall_d  = perf_stall_q + 32'(I_start && full);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs, decoded from registers only
    // ------------------------------------------------------------------------
    assign stall     = full;
    assign DONE      = (level_q == '0) && (state_q == StIdle);
    assign iss_valid = (state_q == StOffer);
    assign iss_pkt   = iss_pkt_q;
    assign iss_vl    = iss_vl_q;
    assign iss_id    = iss_id_q;
    assign level     = level_q;

endmodule
